// File: rtl/spi_xfer_queue.sv
// Byte-queue front end for spi_master: a TX FIFO feeds words one at a time through the
// enable/done handshake, and every received word lands in an RX FIFO for the host.
module spi_xfer_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_wr_en,
  input  logic [DATA_WIDTH-1:0] tx_wr_data,
  output logic                  tx_full,
  output logic [ADDR_WIDTH:0]   tx_count,
  input  logic                  rx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_rd_data,
  output logic                  rx_empty,
  output logic [ADDR_WIDTH:0]   rx_count,
  input  logic                  ovf_clr,
  output logic                  tx_overflow,
  output logic                  busy,
  output logic                  spi_enable,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  input  logic                  spi_done,
  input  logic [DATA_WIDTH-1:0] spi_rx_data
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [ADDR_WIDTH-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [ADDR_WIDTH:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [DATA_WIDTH-1:0] rx_rd_data_q, rx_rd_data_d;
  logic [DATA_WIDTH-1:0] spi_tx_data_q, spi_tx_data_d;
  logic                  spi_enable_q, spi_enable_d;
  logic                  tx_overflow_q, tx_overflow_d;
  logic                  tx_push, tx_pop, rx_push, rx_pop;

  // Fullness is judged on the registered count, so a same-cycle FSM pop never rescues a push.
  always_comb begin
    tx_push       = tx_wr_en && (tx_count_q != FULL_CNT);
    tx_pop        = (state_q == S_LOAD);
    rx_push       = (state_q == S_WAIT) && !spi_enable_q && spi_done;
    rx_pop        = rx_rd_en && (rx_count_q != '0);

    tx_mem_d      = tx_mem_q;
    rx_mem_d      = rx_mem_q;
    tx_wr_ptr_d   = tx_wr_ptr_q;
    tx_rd_ptr_d   = tx_rd_ptr_q;
    rx_wr_ptr_d   = rx_wr_ptr_q;
    rx_rd_ptr_d   = rx_rd_ptr_q;
    tx_count_d    = tx_count_q;
    rx_count_d    = rx_count_q;
    rx_rd_data_d  = rx_rd_data_q;
    tx_overflow_d = tx_overflow_q;

    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = tx_wr_data;
      tx_wr_ptr_d           = tx_wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   tx_count_d = tx_count_q - (ADDR_WIDTH + 1)'(1);
      default: tx_count_d = tx_count_q;
    endcase

    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = spi_rx_data;
      rx_wr_ptr_d           = rx_wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rx_pop) begin
      rx_rd_data_d = rx_mem_q[rx_rd_ptr_q];
      rx_rd_ptr_d  = rx_rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   rx_count_d = rx_count_q - (ADDR_WIDTH + 1)'(1);
      default: rx_count_d = rx_count_q;
    endcase

    // A new overflow outranks a clear arriving in the same cycle.
    if (tx_wr_en && (tx_count_q == FULL_CNT)) begin
      tx_overflow_d = 1'b1;
    end else if (ovf_clr) begin
      tx_overflow_d = 1'b0;
    end
  end

  // A transfer starts only when RX has room for its result, so RX can never overflow.
  always_comb begin
    state_d       = state_q;
    spi_enable_d  = 1'b0;
    spi_tx_data_d = spi_tx_data_q;
    case (state_q)
      S_IDLE: begin
        if ((tx_count_q != '0) && (rx_count_q < FULL_CNT)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        spi_tx_data_d = tx_mem_q[tx_rd_ptr_q];
        spi_enable_d  = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (!spi_enable_q && spi_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      tx_count_q    <= '0;
      rx_count_q    <= '0;
      rx_rd_data_q  <= '0;
      spi_tx_data_q <= '0;
      spi_enable_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      tx_count_q    <= tx_count_d;
      rx_count_q    <= rx_count_d;
      rx_rd_data_q  <= rx_rd_data_d;
      spi_tx_data_q <= spi_tx_data_d;
      spi_enable_q  <= spi_enable_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  // Storage needs no reset: the pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  assign tx_full     = (tx_count_q == FULL_CNT);
  assign tx_count    = tx_count_q;
  assign rx_rd_data  = rx_rd_data_q;
  assign rx_empty    = (rx_count_q == '0);
  assign rx_count    = rx_count_q;
  assign tx_overflow = tx_overflow_q;
  assign busy        = (state_q != S_IDLE);
  assign spi_enable  = spi_enable_q;
  assign spi_tx_data = spi_tx_data_q;

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Self-checking bench for spi_xfer_queue: directed scenarios plus a randomized phase,
// checked against a queue-based model of what the host pushed and an spi_master model.
module tb_spi_xfer_queue;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_wr_en;
  logic [7:0] tx_wr_data;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       rx_rd_en;
  logic [7:0] rx_rd_data;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       ovf_clr;
  logic       tx_overflow;
  logic       busy;
  logic       spi_enable;
  logic [7:0] spi_tx_data;
  logic       spi_done;
  logic [7:0] spi_rx_data;

  spi_xfer_queue #(.DATA_WIDTH(8), .DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_count(tx_count),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .ovf_clr(ovf_clr), .tx_overflow(tx_overflow), .busy(busy),
    .spi_enable(spi_enable), .spi_tx_data(spi_tx_data),
    .spi_done(spi_done), .spi_rx_data(spi_rx_data)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else pass_count++;
  endtask

  // spi_master model settings (written by the test) and observations (written by the model).
  logic       master_stall    = 1'b0;
  logic       master_rand     = 1'b0;
  int         master_delay    = 10;
  logic [7:0] mask            = 8'h00;
  logic       gap_check_en    = 1'b0;
  int         inject_req      = 0;
  int         inject_ack      = 0;
  int         done_count      = 0;
  int         countdown       = 0;
  logic [7:0] resp            = 8'h00;
  int         last_done_cyc   = 0;
  logic       last_done_valid = 1'b0;
  logic [7:0] seen_tx[$];

  // Master model: returns tx_data ^ mask after a delay, records every enable pulse.
  initial begin
    spi_done    = 1'b0;
    spi_rx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      spi_done = 1'b0;
      if (!gap_check_en) last_done_valid = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          spi_done        = 1'b1;
          spi_rx_data     = resp;
          done_count++;
          last_done_cyc   = cyc;
          last_done_valid = gap_check_en;
        end
      end
      if (inject_ack != inject_req) begin
        spi_done    = 1'b1;
        spi_rx_data = 8'hEE;
        inject_ack++;
      end
      if (spi_enable === 1'b1) begin
        seen_tx.push_back(spi_tx_data);
        if (gap_check_en && last_done_valid) checkOutput("enable_gap", cyc - last_done_cyc, 3);
        if (!master_stall) begin
          countdown = master_rand ? int'($urandom_range(1, 6)) : master_delay;
          resp      = spi_tx_data ^ mask;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  logic [7:0] pushed[$];
  int         reads, tx_base, done_base, avail, guard;
  logic       w, r;
  logic [7:0] d;

  // One host cycle: inputs are applied at a negedge and sampled by the following posedge.
  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic rd,
                               input logic clr);
    tx_wr_en   = wr;
    tx_wr_data = data;
    rx_rd_en   = rd;
    ovf_clr    = clr;
    @(negedge clk);
    tx_wr_en = 1'b0;
    rx_rd_en = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  task automatic waitDones(input int target, input int budget);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_done", done_count, target);
    idle(2);
  endtask

  task automatic startTest();
    pushed.delete();
    reads     = 0;
    tx_base   = seen_tx.size();
    done_base = done_count;
  endtask

  initial begin
    rst = 1'b0; tx_wr_en = 1'b0; tx_wr_data = 8'h00; rx_rd_en = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    idle(2);
    rst = 1'b1;

    // Reset state, then an empty queue must stay quiet.
    checkOutput("rst_rx_empty", rx_empty, 1);
    checkOutput("rst_tx_count", tx_count, 0);
    checkOutput("rst_rx_count", rx_count, 0);
    checkOutput("rst_tx_full", tx_full, 0);
    checkOutput("rst_enable", spi_enable, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ovf", tx_overflow, 0);
    checkOutput("rst_rd_data", rx_rd_data, 0);
    checkOutput("rst_spi_tx", spi_tx_data, 0);
    startTest();
    idle(20);
    checkOutput("idle_no_enable", seen_tx.size() - tx_base, 0);

    // Single byte.
    mask = 8'h99; master_delay = 10;
    startTest();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    waitDones(done_base + 1, 60);
    checkOutput("single_enables", seen_tx.size() - tx_base, 1);
    checkOutput("single_tx_data", seen_tx[tx_base], 8'hA5);
    checkOutput("single_rx_count", rx_count, 1);
    checkOutput("single_busy", busy, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("single_rd_data", rx_rd_data, 8'h3C);
    checkOutput("single_rx_empty", rx_empty, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("empty_rd_hold", rx_rd_data, 8'h3C);
    checkOutput("empty_rd_count", rx_count, 0);

    // Burst with ordering and inter-word spacing.
    mask = 8'hFF; gap_check_en = 1'b1;
    startTest();
    for (int i = 1; i <= 5; i++) begin
      pushed.push_back(8'(i));
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    end
    waitDones(done_base + 5, 200);
    gap_check_en = 1'b0;
    checkOutput("burst_enables", seen_tx.size() - tx_base, 5);
    checkOutput("burst_rx_count", rx_count, 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("burst_tx_order", seen_tx[tx_base + i], pushed[i]);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("burst_rd_data", rx_rd_data, pushed[i] ^ 8'hFF);
    end

    // TX overflow with the master stalled.
    master_stall = 1'b1;
    doReset();
    startTest();
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      pushed.push_back(d);
      applyStimulus(1'b1, d, 1'b0, 1'b0);
    end
    checkOutput("ovf_17_ok", tx_overflow, 0);
    checkOutput("ovf_tx_count", tx_count, 16);
    checkOutput("ovf_tx_full", tx_full, 1);
    checkOutput("ovf_first_word", seen_tx[tx_base], pushed[0]);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("ovf_set", tx_overflow, 1);
    checkOutput("ovf_count_held", tx_count, 16);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_clr", tx_overflow, 0);
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b1);
    checkOutput("ovf_set_wins", tx_overflow, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_clr2", tx_overflow, 0);

    // RX back-pressure: the host never reads.
    master_stall = 1'b0; mask = 8'h5A; master_delay = 2;
    doReset();
    startTest();
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      pushed.push_back(d);
      applyStimulus(1'b1, d, 1'b0, 1'b0);
      idle(2);
    end
    idle(150);
    checkOutput("bp_enables", seen_tx.size() - tx_base, 16);
    checkOutput("bp_dones", done_count - done_base, 16);
    checkOutput("bp_rx_count", rx_count, 16);
    checkOutput("bp_tx_count", tx_count, 4);
    checkOutput("bp_busy", busy, 0);
    checkOutput("bp_ovf", tx_overflow, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("bp_rd_data", rx_rd_data, pushed[0] ^ 8'h5A);
    idle(30);
    checkOutput("bp_one_more", seen_tx.size() - tx_base, 17);
    checkOutput("bp_17th_word", seen_tx[tx_base + 16], pushed[16]);
    checkOutput("bp_rx_refill", rx_count, 16);
    checkOutput("bp_tx_after", tx_count, 3);

    // Reset in the middle of a transfer, then a late done.
    master_stall = 1'b1;
    doReset();
    startTest();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    idle(3);
    checkOutput("mid_busy", busy, 1);
    checkOutput("mid_tx_count", tx_count, 3);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    inject_req++;
    idle(4);
    checkOutput("mid_busy_after", busy, 0);
    checkOutput("mid_tx_after", tx_count, 0);
    checkOutput("mid_rx_after", rx_count, 0);
    checkOutput("mid_rx_empty", rx_empty, 1);
    checkOutput("mid_enables", seen_tx.size() - tx_base, 1);

    // Randomized traffic: random pushes, pops and master latency.
    master_stall = 1'b0; master_rand = 1'b1; mask = 8'($urandom);
    doReset();
    startTest();
    for (int i = 0; i < 500; i++) begin
      avail = (done_count - done_base) - reads - (spi_done ? 1 : 0);
      w = ($urandom_range(0, 2) == 0) &&
          ((pushed.size() - (seen_tx.size() - tx_base)) < DEPTH);
      r = (avail > 0) && ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      if (w) pushed.push_back(d);
      applyStimulus(w, d, r, 1'b0);
      if (r) begin
        checkOutput("rand_rd_data", rx_rd_data, pushed[reads] ^ mask);
        reads++;
      end
    end
    guard = 0;
    while (reads < pushed.size() && guard < 3000) begin
      avail = (done_count - done_base) - reads - (spi_done ? 1 : 0);
      if (avail > 0) begin
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain_rd_data", rx_rd_data, pushed[reads] ^ mask);
        reads++;
      end else begin
        idle(1);
      end
      guard++;
    end
    checkOutput("drain_all_read", reads, pushed.size());
    idle(2);
    checkOutput("drain_tx_count", tx_count, 0);
    checkOutput("drain_rx_count", rx_count, 0);
    checkOutput("drain_busy", busy, 0);
    checkOutput("drain_ovf", tx_overflow, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/spi_xfer_queue.md
Name: spi_xfer_queue

Overview:
- Byte-queue front end sitting directly upstream of spi_master.
- Host pushes TX bytes into an internal FIFO. The block feeds them to spi_master one at a time using the enable/done handshake, and stores each received byte in an RX FIFO for the host to read.
- Decouples host timing from SPI bit timing.
- Applies RX back-pressure so no received byte is ever lost.

Parameters:
- DATA_WIDTH, 8, width of each SPI word; matches spi_master DATA_WIDTH.
- DEPTH, 16, entries per FIFO; must be a power of two, at least 2.
- ADDR_WIDTH, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- tx_wr_en  in  1  host push strobe for TX FIFO.
- tx_wr_data  in  DATA_WIDTH  byte to transmit.
- tx_full  out  1  TX FIFO holds DEPTH entries.
- tx_count  out  ADDR_WIDTH+1  TX occupancy.
- rx_rd_en  in  1  host pop strobe for RX FIFO.
- rx_rd_data  out  DATA_WIDTH  popped byte, registered.
- rx_empty  out  1  RX FIFO holds 0 entries.
- rx_count  out  ADDR_WIDTH+1  RX occupancy.
- ovf_clr  in  1  clears tx_overflow.
- tx_overflow  out  1  sticky: a push was attempted while full.
- busy  out  1  state is not IDLE.
- spi_enable  out  1  one-cycle start pulse to spi_master.
- spi_tx_data  out  DATA_WIDTH  word presented to spi_master; held until the next LOAD.
- spi_done  in  1  one-cycle completion pulse from spi_master.
- spi_rx_data  in  DATA_WIDTH  received word; valid in the spi_done cycle.

Behaviour:
- Reset (rst=0 at a rising edge) applies regardless of state:
  - state=IDLE; both FIFOs emptied (pointers and counts 0).
  - tx_full=0, rx_empty=1, tx_count=0, rx_count=0.
  - rx_rd_data=0, spi_tx_data=0, spi_enable=0, tx_overflow=0, busy=0.
  - Reset mid-transfer abandons the word; a late spi_done after reset is ignored because the state is IDLE.
- TX push:
  - tx_wr_en=1 and tx_full=0: the word is written and tx_count increments at the next edge.
  - tx_wr_en=1 and tx_full=1: the word is dropped and tx_overflow is set.
  - Fullness is judged on that cycle's tx_full, even if the FSM pops in the same cycle.
- ovf_clr=1 clears tx_overflow. If ovf_clr and a new overflow occur in the same cycle, set wins.
- RX pop:
  - rx_rd_en=1 and rx_empty=0: rx_rd_data takes the head word at the next edge and rx_count decrements.
  - rx_rd_en=1 and rx_empty=1: ignored; rx_rd_data holds its value.
- Counts:
  - Each count changes by at most 1 per cycle.
  - A simultaneous push and pop on the same FIFO leaves its count unchanged.
  - Pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
- FSM, 3 states:
  - IDLE -> LOAD when tx_count!=0 and (rx_count + pending) < DEPTH. pending is always 0 in IDLE, so the condition reduces to rx_count<DEPTH.
  - LOAD, exactly 1 cycle: pop the TX head into spi_tx_data, decrement tx_count, register spi_enable=1 for the following cycle. Go to WAIT.
  - WAIT: spi_enable=1 in the first WAIT cycle only, then 0. On spi_done=1, push spi_rx_data into the RX FIFO and go to IDLE.
- An RX push in the same cycle as a host RX pop is legal.
- RX overflow cannot occur: a transfer only starts when RX has space, and the host can only make more room meanwhile.
- spi_done is ignored in IDLE and LOAD, and ignored during the spi_enable cycle itself.
- Minimum per-word overhead: 3 clk cycles beyond the spi_master transfer time (IDLE, LOAD, enable cycle). Back-to-back words re-enter LOAD on the cycle after IDLE.
- busy=1 in LOAD and WAIT.

Test Plan:
- Reset then idle: rst low 2 cycles -> rx_empty=1, tx_count=0, spi_enable=0, busy=0; no spi_enable pulse over 20 cycles with an empty queue.
- Single byte: push 0xA5, master model returns 0x3C with done 10 cycles after enable -> exactly one spi_enable pulse with spi_tx_data=0xA5; rx_count=1; rx_rd_en gives rx_rd_data=0x3C the next cycle.
- Burst with ordering: push 0x01..0x05 back-to-back, master echoes each byte XOR 0xFF -> 5 enable pulses in order 0x01..0x05; RX reads 0xFE,0xFD,0xFC,0xFB,0xFA; each enable occurs 3 cycles after the previous done.
- TX overflow: push 17 bytes while the master is stalled (done withheld) -> after the first pop, the 17th push still succeeds; an 18th push while full sets tx_overflow=1 and tx_count stays 16; ovf_clr -> tx_overflow=0.
- RX back-pressure: host never reads, push 20 bytes -> exactly 16 transfers; rx_count=16; no enable pulse after the 16th done; one rx_rd_en -> one further transfer.
- Reset mid-transfer: rst low during WAIT with 3 words queued, spi_done pulsed 2 cycles after reset release -> state IDLE, tx_count=0, rx_count=0, no RX push.
